xor_check_sequencer: RTL
========================

// Module: xor_check_sequencer
// PURPOSE
//  Stimulus/check controller for the x[63:0] -> {badness,goodness} XOR-concat compare datapath.
//  On start, issues NUM_VECTORS pseudo-random 64-bit vectors (Galois LFSR), one per cycle.
//  Checks both flags through one register stage, counts failing vectors, captures the first failing x.
//  Sits between the testbench/harness control and the combinational compare datapath.
// PARAMETERS
//  NUM_VECTORS  1024                   vectors per run; must be >=1 (elaboration $error otherwise)
//  CNT_W        16                     width of err_count and vec_count
//  SEED         64'h0123_4567_89AB_CDEF default LFSR seed; also substitutes any zero seed
// PORTS
//  clk          in   1      clock; all state on rising edge
//  reset_l      in   1      asynchronous, active-low reset
//  start        in   1      run request; sampled only in IDLE or DONE
//  seed_load    in   1      in IDLE/DONE: load seed into LFSR this cycle (start has priority)
//  seed         in   64     seed value for seed_load
//  x_out        out  64     vector to datapath x (the LFSR register itself)
//  x_valid      out  1      x_out is a live vector this cycle
//  badness_in   in   1      datapath badness for current x_out (combinational path)
//  goodness_in  in   1      datapath goodness for current x_out
//  busy         out  1      state is RUN or DRAIN
//  done         out  1      state is DONE (level, held until next accepted start)
//  vec_count    out  CNT_W  vectors checked this run, saturating
//  err_count    out  CNT_W  vectors with badness_in|goodness_in, saturating at all-ones
//  first_err_x  out  64     x of first failing vector of the run
//  first_err_v  out  1      first_err_x is valid
// BEHAVIOUR
//  Reset: state=IDLE, LFSR=SEED, x_valid=busy=done=first_err_v=0, counts=0, first_err_x=0.
//  Reset mid-run: immediate abort to the reset values; no partial results are kept.
//  LFSR: Galois right shift, poly x^64+x^63+x^61+x^60+1:
//   next = (s>>1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 0). Advances only in RUN.
//  Zero seed (seed_load with seed==0) loads SEED instead; the LFSR never holds 0.
//  FSM:
//   IDLE -start-> RUN (clear counts, first_err_v; LFSR keeps current value as vector 0).
//   RUN: x_valid=1; NUM_VECTORS cycles; after the last one -> DRAIN.
//   DRAIN: one cycle, x_valid=0; the registered check of the last vector is counted; -> DONE.
//   DONE: done=1; results held; start -> RUN (new run), seed_load as in IDLE.
//  Check stage: each x_valid cycle registers {x_out, badness_in, goodness_in, 1}; next cycle,
//   if valid: vec_count++; if bad|good: err_count++ and, if !first_err_v, first_err_x<=x, first_err_v<=1.
//  Timing: start accepted at edge 0 -> vectors on edges 1..N -> DRAIN at N+1 -> done=1 from cycle N+2.
//  LFSR continues from its last state across runs unless reloaded (no implicit reseed).
//  start while busy: ignored. start and seed_load together: start wins, seed ignored.
//  Counter saturation: err_count/vec_count stop at 2^CNT_W-1 and do not wrap.
// CONFIGURATION
//  XORCHK_STOP_ON_ERR_EN defined: a failing result in the check stage during RUN forces
//   RUN->DRAIN next cycle. The vector on x_out in that cycle is still checked; no further vectors are issued.
//   vec_count reflects only the vectors actually issued.
//  Not defined: always runs all NUM_VECTORS vectors regardless of failures.
// TESTING
//  T1 reset: assert reset_l=0 mid-RUN -> all outputs at reset values same cycle, state IDLE.
//  T2 seed_load seed=64'h1, start, NUM_VECTORS=4, clean datapath -> x_out 1, D800..00, 6C00..00,
//     3600..00; done at cycle 6; vec_count=4, err_count=0, first_err_v=0.
//  T3 seed_load seed=0 -> first x_out equals SEED (64'h0123_4567_89AB_CDEF).
//  T4 model flags badness on vectors 2 and 3 (seed 1, N=4) -> err_count=2, first_err_x=64'hD800_0000_0000_0000.
//  T5 XORCHK_STOP_ON_ERR_EN, same stimulus as T4 -> err_count=2, vec_count=3, done at cycle 5.
//  T6 CNT_W=2, N=8, all vectors fail -> err_count=vec_count=3 (saturated); start during RUN ignored.

Source files
------------

// File: rtl/xor_check_sequencer.sv
// Stimulus/check sequencer for the XOR-concat compare datapath: issues LFSR vectors,
// registers the datapath flags one stage, and tallies results. Option: XORCHK_STOP_ON_ERR_EN.
module xor_check_sequencer #(
  parameter int          NUM_VECTORS = 1024,
  parameter int          CNT_W       = 16,
  parameter logic [63:0] SEED        = 64'h0123_4567_89AB_CDEF
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic             seed_load,
  input  logic [63:0]      seed,
  output logic [63:0]      x_out,
  output logic             x_valid,
  input  logic             badness_in,
  input  logic             goodness_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [63:0]      first_err_x,
  output logic             first_err_v
);

  localparam logic [63:0]      TAPS     = 64'hD800_0000_0000_0000;
  localparam int               ISS_W    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
  localparam logic [ISS_W-1:0] LAST_IDX = ISS_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  if (NUM_VECTORS < 1) begin : g_bad_num_vectors
    $error("xor_check_sequencer: NUM_VECTORS must be >= 1");
  end
  if (SEED == 64'd0) begin : g_bad_seed
    $error("xor_check_sequencer: SEED must be non-zero");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        lfsr_q, lfsr_d;
  logic [ISS_W-1:0]   iss_cnt_q, iss_cnt_d;
  logic               x_valid_q, x_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [63:0]        chk_x_q, chk_x_d;
  logic               chk_bad_q, chk_bad_d;
  logic               chk_good_q, chk_good_d;
  logic               chk_v_q, chk_v_d;
  logic [CNT_W-1:0]   vec_count_q, vec_count_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [63:0]        first_err_x_q, first_err_x_d;
  logic               first_err_v_q, first_err_v_d;

  logic [63:0]        lfsr_adv;
  logic               chk_fail;

  // Galois right-shift step: bit 0 feeds back into the tap positions.
  for (genvar gi = 0; gi < 64; gi++) begin : g_lfsr
    if (gi == 63) begin : g_top
      assign lfsr_adv[gi] = TAPS[gi] & lfsr_q[0];
    end else begin : g_mid
      assign lfsr_adv[gi] = lfsr_q[gi+1] ^ (TAPS[gi] & lfsr_q[0]);
    end
  end

  assign chk_fail = chk_v_q & (chk_bad_q | chk_good_q);

  always_comb begin
    state_d       = state_q;
    lfsr_d        = lfsr_q;
    iss_cnt_d     = iss_cnt_q;
    vec_count_d   = vec_count_q;
    err_count_d   = err_count_q;
    first_err_x_d = first_err_x_q;
    first_err_v_d = first_err_v_q;

    // Check stage: retire the vector registered on the previous edge.
    if (chk_v_q) begin
      if (vec_count_q != CNT_MAX) vec_count_d = vec_count_q + 1'b1;
      if (chk_bad_q | chk_good_q) begin
        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
        if (!first_err_v_q) begin
          first_err_x_d = chk_x_q;
          first_err_v_d = 1'b1;
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d       = S_RUN;
          iss_cnt_d     = '0;
          vec_count_d   = '0;
          err_count_d   = '0;
          first_err_v_d = 1'b0;
        end else if (seed_load) begin
          lfsr_d = (seed == 64'd0) ? SEED : seed;
        end
      end
      S_RUN: begin
        lfsr_d    = lfsr_adv;
        iss_cnt_d = iss_cnt_q + 1'b1;
        if (iss_cnt_q == LAST_IDX) state_d = S_DRAIN;
`ifdef XORCHK_STOP_ON_ERR_EN
        // The vector currently on x_out is still registered; nothing after it is issued.
        if (chk_fail) state_d = S_DRAIN;
`endif
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    chk_v_d    = x_valid_q;
    chk_x_d    = lfsr_q;
    chk_bad_d  = badness_in;
    chk_good_d = goodness_in;

    x_valid_d = (state_d == S_RUN);
    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= S_IDLE;
      lfsr_q        <= SEED;
      iss_cnt_q     <= '0;
      x_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      chk_x_q       <= '0;
      chk_bad_q     <= 1'b0;
      chk_good_q    <= 1'b0;
      chk_v_q       <= 1'b0;
      vec_count_q   <= '0;
      err_count_q   <= '0;
      first_err_x_q <= '0;
      first_err_v_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      iss_cnt_q     <= iss_cnt_d;
      x_valid_q     <= x_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      chk_x_q       <= chk_x_d;
      chk_bad_q     <= chk_bad_d;
      chk_good_q    <= chk_good_d;
      chk_v_q       <= chk_v_d;
      vec_count_q   <= vec_count_d;
      err_count_q   <= err_count_d;
      first_err_x_q <= first_err_x_d;
      first_err_v_q <= first_err_v_d;
    end
  end

  assign x_out       = lfsr_q;
  assign x_valid     = x_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign vec_count   = vec_count_q;
  assign err_count   = err_count_q;
  assign first_err_x = first_err_x_q;
  assign first_err_v = first_err_v_q;

  a_lfsr_nonzero: assert property (@(posedge clk) disable iff (!reset_l) lfsr_q != 64'd0);
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!reset_l) !(busy_q && done_q));

endmodule
